// File: rtl/wb_arbiter_pkg.sv
// Shared writeback datapath types: buffered FU result entry and tag helpers.
// The FU count and widths here are the defaults for wb_arbiter.
package wb_arbiter_pkg;
    localparam int NUM_FU   = 4;
    localparam int NUM_REGS = 32;
    localparam int TAG_W    = 3;
    localparam int DATA_W   = 32;
    localparam int CNT_W    = 16;
    localparam int REG_W    = $clog2(NUM_REGS);

    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Tag 0 means "no owner"; tags above NUM_FU name no producer. Neither may retire.
    function automatic logic tag_live(input logic [TAG_W-1:0] t);
        return (t != TAG_NONE) && (int'(t) <= NUM_FU);
    endfunction
endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin picker: one-hot grant to the first requester at or after ptr, circularly.
// Generic in N so the dispatch side can reuse it.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] gidx,
    output logic          gvalid
);
    int idx;

    // Scan from the farthest offset down so the nearest requester is written last and wins.
    always_comb begin
        grant  = '0;
        gidx   = '0;
        gvalid = 1'b0;
        idx    = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = (int'(ptr) + off) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                gidx       = IW'(idx);
                gvalid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding buffer per FU, round-robin retire of one result per cycle,
// dropping results whose tag no longer owns the destination register in the status table.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter  int NUM_FU   = wb_arbiter_pkg::NUM_FU,
    parameter  int NUM_REGS = wb_arbiter_pkg::NUM_REGS,
    parameter  int TAG_W    = wb_arbiter_pkg::TAG_W,
    parameter  int DATA_W   = wb_arbiter_pkg::DATA_W,
    parameter  int CNT_W    = wb_arbiter_pkg::CNT_W,
    localparam int REG_W    = $clog2(NUM_REGS),
    localparam int PW       = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic                           flush,
    input  logic [NUM_FU-1:0]              fu_valid,
    output logic [NUM_FU-1:0]              fu_ready,
    input  logic [NUM_FU-1:0][REG_W-1:0]   fu_rd,
    input  logic [NUM_FU-1:0][TAG_W-1:0]   fu_tag,
    input  logic [NUM_FU-1:0][DATA_W-1:0]  fu_data,
    input  logic [NUM_REGS-1:0]            st_busy,
    input  logic [NUM_REGS-1:0][TAG_W-1:0] st_tag,
    output logic                           wb_write,
    output logic [REG_W-1:0]               wb_sel,
    output logic [TAG_W-1:0]               wb_tag,
    output logic [DATA_W-1:0]              wb_data,
    output logic                           stale_drop,
    output logic [CNT_W-1:0]               drop_cnt
);
    if ((1 << TAG_W) <= NUM_FU) begin : g_bad_tag_w
        $error("wb_arbiter: TAG_W cannot hold NUM_FU");
    end
    if (TAG_W != wb_arbiter_pkg::TAG_W || DATA_W != wb_arbiter_pkg::DATA_W ||
        REG_W != wb_arbiter_pkg::REG_W) begin : g_bad_entry_w
        $error("wb_arbiter: widths disagree with wb_entry_t");
    end

    wb_entry_t             buf_q [NUM_FU];
    wb_entry_t             buf_d [NUM_FU];
    wb_entry_t             sel;
    logic [NUM_FU-1:0]     full_q, full_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic                  wb_write_q, wb_write_d;
    logic [REG_W-1:0]      wb_sel_q, wb_sel_d;
    logic [TAG_W-1:0]      wb_tag_q, wb_tag_d;
    logic [DATA_W-1:0]     wb_data_q, wb_data_d;
    logic                  stale_drop_q, stale_drop_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic [NUM_FU-1:0]     grant;
    logic [PW-1:0]         gidx;
    logic                  gvalid;
    logic                  match;

    rr_arbiter #(.N(NUM_FU)) u_rr (
        .req    (full_q),
        .ptr    (rr_ptr_q),
        .grant  (grant),
        .gidx   (gidx),
        .gvalid (gvalid)
    );

    // A buffer being drained this cycle can be refilled in the same cycle.
    assign fu_ready = flush ? '0 : (~full_q | grant);

    always_comb begin
        full_d       = full_q;
        buf_d        = buf_q;
        rr_ptr_d     = rr_ptr_q;
        wb_write_d   = 1'b0;
        stale_drop_d = 1'b0;
        wb_sel_d     = wb_sel_q;
        wb_tag_d     = wb_tag_q;
        wb_data_d    = wb_data_q;
        drop_cnt_d   = drop_cnt_q;
        sel          = buf_q[gidx];
        match        = tag_live(sel.tag) && st_busy[sel.rd] && (st_tag[sel.rd] == sel.tag);

        if (flush) begin
            full_d = '0;
        end else begin
            full_d = full_q & ~grant;
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    full_d[i] = 1'b1;
                    buf_d[i]  = '{rd: fu_rd[i], tag: fu_tag[i], data: fu_data[i]};
                end
            end
            if (gvalid) begin
                rr_ptr_d = PW'((int'(gidx) + 1) % NUM_FU);
                if (match) begin
                    wb_write_d = 1'b1;
                    wb_sel_d   = sel.rd;
                    wb_tag_d   = sel.tag;
                    wb_data_d  = sel.data;
                end else begin
                    stale_drop_d = 1'b1;
                    if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            full_q       <= '0;
            buf_q        <= '{default: '0};
            rr_ptr_q     <= '0;
            wb_write_q   <= 1'b0;
            wb_sel_q     <= '0;
            wb_tag_q     <= '0;
            wb_data_q    <= '0;
            stale_drop_q <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            full_q       <= full_d;
            buf_q        <= buf_d;
            rr_ptr_q     <= rr_ptr_d;
            wb_write_q   <= wb_write_d;
            wb_sel_q     <= wb_sel_d;
            wb_tag_q     <= wb_tag_d;
            wb_data_q    <= wb_data_d;
            stale_drop_q <= stale_drop_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign wb_write   = wb_write_q;
    assign wb_sel     = wb_sel_q;
    assign wb_tag     = wb_tag_q;
    assign wb_data    = wb_data_q;
    assign stale_drop = stale_drop_q;
    assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single-result vector table plus multi-cycle sequences
// for round-robin order, same-cycle refill, flush, counter saturation and async reset.
module tb_wb_arbiter;
    logic                CLK = 1'b0;
    logic                nRST = 1'b0;
    logic                flush = 1'b0;
    logic [3:0]          fu_valid = '0;
    logic [3:0]          fu_ready;
    logic [3:0][4:0]     fu_rd = '0;
    logic [3:0][2:0]     fu_tag = '0;
    logic [3:0][31:0]    fu_data = '0;
    logic [31:0]         st_busy = '0;
    logic [31:0][2:0]    st_tag = '0;
    logic                wb_write;
    logic [4:0]          wb_sel;
    logic [2:0]          wb_tag;
    logic [31:0]         wb_data;
    logic                stale_drop;
    logic [15:0]         drop_cnt;

    int nvec = 0;
    int nerr = 0;

    wb_arbiter dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready), .fu_rd(fu_rd), .fu_tag(fu_tag),
        .fu_data(fu_data), .st_busy(st_busy), .st_tag(st_tag),
        .wb_write(wb_write), .wb_sel(wb_sel), .wb_tag(wb_tag), .wb_data(wb_data),
        .stale_drop(stale_drop), .drop_cnt(drop_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          fu;
        logic [4:0]  rd;
        logic [2:0]  tag;
        logic [31:0] data;
        logic        busy;
        logic [2:0]  sttag;
        logic        exp_wr;
        logic        exp_stale;
        logic [4:0]  exp_sel;
        logic [2:0]  exp_tag;
        logic [31:0] exp_data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic offer(input int i, input logic [4:0] rd, input logic [2:0] tag, input logic [31:0] d);
        fu_valid[i] = 1'b1;
        fu_rd[i]    = rd;
        fu_tag[i]   = tag;
        fu_data[i]  = d;
    endtask

    task automatic own(input logic [4:0] rd, input logic [2:0] tag);
        st_busy[rd] = 1'b1;
        st_tag[rd]  = tag;
    endtask

    task automatic chk_wb(input string name, input logic [4:0] sel, input logic [31:0] d);
        chk({name, ".wr"}, wb_write, 1);
        chk({name, ".sel"}, wb_sel, sel);
        chk({name, ".data"}, wb_data, d);
    endtask

    initial begin
        // fu, rd, tag, data, busy, sttag | wr, stale, sel, tag, data, cnt
        tbl[0] = '{1, 5'd5,  3'd2, 32'hA5A5_0001, 1'b1, 3'd2, 1'b1, 1'b0, 5'd5, 3'd2, 32'hA5A5_0001, 16'd0};
        tbl[1] = '{2, 5'd7,  3'd3, 32'h0000_0777, 1'b1, 3'd1, 1'b0, 1'b1, 5'd5, 3'd2, 32'hA5A5_0001, 16'd1};
        tbl[2] = '{0, 5'd9,  3'd0, 32'h0000_0999, 1'b1, 3'd0, 1'b0, 1'b1, 5'd5, 3'd2, 32'hA5A5_0001, 16'd2};
        tbl[3] = '{1, 5'd2,  3'd5, 32'h0000_0222, 1'b1, 3'd5, 1'b0, 1'b1, 5'd5, 3'd2, 32'hA5A5_0001, 16'd3};
        tbl[4] = '{2, 5'd31, 3'd3, 32'h0000_0031, 1'b0, 3'd3, 1'b0, 1'b1, 5'd5, 3'd2, 32'hA5A5_0001, 16'd4};
        tbl[5] = '{3, 5'd0,  3'd4, 32'hDEAD_BEEF, 1'b1, 3'd4, 1'b1, 1'b0, 5'd0, 3'd4, 32'hDEAD_BEEF, 16'd4};

        #3;
        chk("rst.wr", wb_write, 0);
        chk("rst.sel", wb_sel, 0);
        chk("rst.tag", wb_tag, 0);
        chk("rst.data", wb_data, 0);
        chk("rst.stale", stale_drop, 0);
        chk("rst.cnt", drop_cnt, 0);
        chk("rst.ready", fu_ready, 4'hF);
        tick();
        nRST = 1'b1;
        tick();

        // Single-result vectors: accept, one idle-output cycle, then result on the next.
        for (int v = 0; v < 6; v++) begin
            st_busy = '0;
            st_tag  = '0;
            st_busy[tbl[v].rd] = tbl[v].busy;
            st_tag[tbl[v].rd]  = tbl[v].sttag;
            offer(tbl[v].fu, tbl[v].rd, tbl[v].tag, tbl[v].data);
            chk($sformatf("v%0d.rdy", v), fu_ready[tbl[v].fu], 1);
            tick();
            fu_valid = '0;
            chk($sformatf("v%0d.early", v), wb_write | stale_drop, 0);
            tick();
            chk($sformatf("v%0d.wr", v), wb_write, tbl[v].exp_wr);
            chk($sformatf("v%0d.stale", v), stale_drop, tbl[v].exp_stale);
            chk($sformatf("v%0d.sel", v), wb_sel, tbl[v].exp_sel);
            chk($sformatf("v%0d.tag", v), wb_tag, tbl[v].exp_tag);
            chk($sformatf("v%0d.data", v), wb_data, tbl[v].exp_data);
            chk($sformatf("v%0d.cnt", v), drop_cnt, tbl[v].exp_cnt);
            chk($sformatf("v%0d.freed", v), fu_ready, 4'hF);
        end

        // All four FUs at once: retire in order 0..3 on consecutive cycles.
        st_busy = '0;
        for (int i = 0; i < 4; i++) begin
            own(5'(10 + i), 3'(i + 1));
            offer(i, 5'(10 + i), 3'(i + 1), 32'h100 + i);
        end
        tick();
        fu_valid = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_wb($sformatf("rr%0d", i), 5'(10 + i), 32'h100 + i);
            chk($sformatf("rr%0d.tag", i), wb_tag, i + 1);
        end
        tick();
        chk("rr.idle", wb_write, 0);

        // Pointer back at 0: FU0 beats FU3 when both arrive together.
        own(5'd20, 3'd4);
        own(5'd21, 3'd1);
        offer(3, 5'd20, 3'd4, 32'h320);
        offer(0, 5'd21, 3'd1, 32'h021);
        tick();
        fu_valid = '0;
        tick();
        chk_wb("ptr0.first", 5'd21, 32'h021);
        tick();
        chk_wb("ptr0.second", 5'd20, 32'h320);

        // FU0 held valid two cycles: refill while draining, no bubble.
        own(5'd3, 3'd1);
        own(5'd4, 3'd1);
        offer(0, 5'd3, 3'd1, 32'h111);
        chk("hold.rdy0", fu_ready[0], 1);
        tick();
        offer(0, 5'd4, 3'd1, 32'h222);
        chk("hold.rdy1", fu_ready[0], 1);
        tick();
        fu_valid = '0;
        chk_wb("hold.wb0", 5'd3, 32'h111);
        tick();
        chk_wb("hold.wb1", 5'd4, 32'h222);
        tick();
        chk("hold.idle", wb_write, 0);

        // Flush with all buffers full.
        for (int i = 0; i < 4; i++) offer(i, 5'(10 + i), 3'(i + 1), 32'h500 + i);
        tick();
        fu_valid = '0;
        flush = 1'b1;
        #1;
        chk("flush.rdy", fu_ready, 4'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush.wr", wb_write, 0);
        chk("flush.stale", stale_drop, 0);
        chk("flush.rdy_after", fu_ready, 4'hF);
        chk("flush.cnt", drop_cnt, 16'd4);
        tick();
        chk("flush.empty", wb_write | stale_drop, 0);

        // Stream 65531 stale results through FU0: counter 4 -> 16'hFFFF exactly.
        offer(0, 5'd1, 3'd0, 32'h0);
        for (int k = 0; k < 65531; k++) tick();
        fu_valid = '0;
        tick();
        chk("sat.stale", stale_drop, 1);
        chk("sat.full", drop_cnt, 16'hFFFF);
        offer(0, 5'd1, 3'd0, 32'h0);
        tick();
        fu_valid = '0;
        tick();
        chk("sat.again_stale", stale_drop, 1);
        chk("sat.hold", drop_cnt, 16'hFFFF);

        // Async reset in the middle of a burst.
        for (int i = 0; i < 4; i++) offer(i, 5'(10 + i), 3'(i + 1), 32'h700 + i);
        tick();
        fu_valid = '0;
        tick();
        chk("mid.wr_before", wb_write, 1);
        #2;
        nRST = 1'b0;
        #1;
        chk("mid.wr", wb_write, 0);
        chk("mid.sel", wb_sel, 0);
        chk("mid.tag", wb_tag, 0);
        chk("mid.data", wb_data, 0);
        chk("mid.stale", stale_drop, 0);
        chk("mid.cnt", drop_cnt, 0);
        chk("mid.rdy", fu_ready, 4'hF);
        #1;
        nRST = 1'b1;
        tick();
        chk("post.wr0", wb_write | stale_drop, 0);
        tick();
        chk("post.wr1", wb_write | stale_drop, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
